// File: rtl/frida_seq_ctrl_if.sv
// Purpose: bundle between the test-side requester and the FRIDA sequencer (request, timing, core clocks, decisions).
// Latency: none, wiring only. FRIDA_SEQ_AUTO_REPEAT_EN adds the auto_repeat request line.
// Backpressure: none; start is a single-cycle request that the sequencer drops while busy.
interface frida_seq_ctrl_if #(
  parameter int NBITS = 16,
  parameter int CNT_W = 8
);
  localparam int NC_W = $clog2(NBITS) + 1;

  logic             start;
  logic [CNT_W-1:0] t_init;
  logic [CNT_W-1:0] t_samp;
  logic [CNT_W-1:0] t_comp;
  logic [CNT_W-1:0] t_logic;
  logic [NC_W-1:0]  n_cycles;
  logic             comp_out;
  logic             seq_init;
  logic             seq_samp;
  logic             seq_comp;
  logic             seq_logic;
  logic             busy;
  logic             done;
  logic [NBITS-1:0] result;

`ifdef FRIDA_SEQ_AUTO_REPEAT_EN
  logic             auto_repeat;

  modport master (
    output start, t_init, t_samp, t_comp, t_logic, n_cycles, comp_out, auto_repeat,
    input  seq_init, seq_samp, seq_comp, seq_logic, busy, done, result
  );
  modport slave (
    input  start, t_init, t_samp, t_comp, t_logic, n_cycles, comp_out, auto_repeat,
    output seq_init, seq_samp, seq_comp, seq_logic, busy, done, result
  );
`else
  modport master (
    output start, t_init, t_samp, t_comp, t_logic, n_cycles, comp_out,
    input  seq_init, seq_samp, seq_comp, seq_logic, busy, done, result
  );
  modport slave (
    input  start, t_init, t_samp, t_comp, t_logic, n_cycles, comp_out,
    output seq_init, seq_samp, seq_comp, seq_logic, busy, done, result
  );
`endif
endinterface

// File: rtl/frida_seq_ctrl.sv
// Purpose: drives seq_init/seq_samp/seq_comp/seq_logic into the FRIDA core and assembles comp_out decisions into result.
// Latency: t_init + t_samp + n_cycles*(t_comp + t_logic) cycles from first INIT to last LOGIC, then one DONE cycle.
// Backpressure: none; start outside IDLE is dropped, not queued. FRIDA_SEQ_AUTO_REPEAT_EN adds auto_repeat.
module frida_seq_ctrl #(
  parameter int NBITS = 16,
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  frida_seq_ctrl_if.slave bus
);
  localparam int NC_W = $clog2(NBITS) + 1;
  localparam logic [NC_W-1:0] NC_MAX = NC_W'(NBITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_SAMP,
    S_COMP,
    S_LOGIC,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lt_init;
  logic [CNT_W-1:0] lt_samp;
  logic [CNT_W-1:0] lt_comp;
  logic [CNT_W-1:0] lt_logic;
  logic [NC_W-1:0]  n_lat;
  logic [NC_W-1:0]  dec_cnt;

  logic [CNT_W-1:0] ti_eff;
  logic [CNT_W-1:0] ts_eff;
  logic [CNT_W-1:0] tc_eff;
  logic [CNT_W-1:0] tl_eff;
  logic [NC_W-1:0]  n_eff;
  logic             last_dec;

  logic             comp_meta;
  logic             comp_sync;

  logic             seq_init_q;
  logic             seq_samp_q;
  logic             seq_comp_q;
  logic             seq_logic_q;
  logic             busy_q;
  logic             done_q;
  logic [NBITS-1:0] result_q;

  logic             auto_rpt;

`ifdef FRIDA_SEQ_AUTO_REPEAT_EN
  assign auto_rpt = bus.auto_repeat;
`else
  assign auto_rpt = 1'b0;
`endif

  // Zero durations and counts run as 1; counts beyond the result width clamp to NBITS.
  always_comb begin
    ti_eff = (bus.t_init  == '0) ? CNT_W'(1) : bus.t_init;
    ts_eff = (bus.t_samp  == '0) ? CNT_W'(1) : bus.t_samp;
    tc_eff = (bus.t_comp  == '0) ? CNT_W'(1) : bus.t_comp;
    tl_eff = (bus.t_logic == '0) ? CNT_W'(1) : bus.t_logic;
    if (bus.n_cycles == '0) begin
      n_eff = NC_W'(1);
    end else if (bus.n_cycles > NC_MAX) begin
      n_eff = NC_MAX;
    end else begin
      n_eff = bus.n_cycles;
    end
  end

  // The decision being taken now is the last one of this conversion.
  assign last_dec = (dec_cnt + NC_W'(1)) >= n_lat;

  // Two-flop synchroniser for the comparator decision, which arrives asynchronously from the core.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      comp_meta <= 1'b0;
      comp_sync <= 1'b0;
    end else begin
      comp_meta <= bus.comp_out;
      comp_sync <= comp_meta;
    end
  end

  // Phase sequencer: each phase loads cnt with duration-1 and counts down to 0; all outputs are flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      lt_init     <= '0;
      lt_samp     <= '0;
      lt_comp     <= '0;
      lt_logic    <= '0;
      n_lat       <= '0;
      dec_cnt     <= '0;
      seq_init_q  <= 1'b0;
      seq_samp_q  <= 1'b0;
      seq_comp_q  <= 1'b0;
      seq_logic_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            lt_init    <= ti_eff;
            lt_samp    <= ts_eff;
            lt_comp    <= tc_eff;
            lt_logic   <= tl_eff;
            n_lat      <= n_eff;
            dec_cnt    <= '0;
            cnt        <= ti_eff - CNT_W'(1);
            result_q   <= '0;
            busy_q     <= 1'b1;
            seq_init_q <= 1'b1;
            state      <= S_INIT;
          end
        end
        S_INIT: begin
          if (cnt == '0) begin
            seq_init_q <= 1'b0;
            seq_samp_q <= 1'b1;
            cnt        <= lt_samp - CNT_W'(1);
            state      <= S_SAMP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_SAMP: begin
          if (cnt == '0) begin
            seq_samp_q <= 1'b0;
            seq_comp_q <= 1'b1;
            cnt        <= lt_comp - CNT_W'(1);
            state      <= S_COMP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_COMP: begin
          if (cnt == '0) begin
            seq_comp_q  <= 1'b0;
            seq_logic_q <= 1'b1;
            cnt         <= lt_logic - CNT_W'(1);
            state       <= S_LOGIC;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_LOGIC: begin
          if (cnt == '0) begin
            result_q    <= {result_q[NBITS-2:0], comp_sync};
            dec_cnt     <= dec_cnt + NC_W'(1);
            seq_logic_q <= 1'b0;
            if (last_dec) begin
              done_q <= 1'b1;
              state  <= S_DONE;
            end else begin
              seq_comp_q <= 1'b1;
              cnt        <= lt_comp - CNT_W'(1);
              state      <= S_COMP;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          if (auto_rpt) begin
            dec_cnt    <= '0;
            cnt        <= lt_init - CNT_W'(1);
            result_q   <= '0;
            seq_init_q <= 1'b1;
            state      <= S_INIT;
          end else begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: begin
          seq_init_q  <= 1'b0;
          seq_samp_q  <= 1'b0;
          seq_comp_q  <= 1'b0;
          seq_logic_q <= 1'b0;
          busy_q      <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.seq_init  = seq_init_q;
  assign bus.seq_samp  = seq_samp_q;
  assign bus.seq_comp  = seq_comp_q;
  assign bus.seq_logic = seq_logic_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_frida_seq_ctrl.sv
// Purpose: self-checking bench for frida_seq_ctrl; phase traces against a timing model, results via a scoreboard.
// Latency: expectations are queued at start and compared on each done pulse.
// Backpressure: none; start pokes while busy must be ignored.
module tb_frida_seq_ctrl;
  localparam int NBITS = 16;
  localparam int CNT_W = 8;
  localparam int NC_W  = $clog2(NBITS) + 1;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [NBITS-1:0] exp_q[$];
  logic [NBITS-1:0] sb_exp;
  int   trace[$];

  always #5 clk = ~clk;

  frida_seq_ctrl_if #(.NBITS(NBITS), .CNT_W(CNT_W)) bif ();

  frida_seq_ctrl #(.NBITS(NBITS), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  // Scoreboard: each done pulse is matched against the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && bif.done === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_spurious_done result=%h with nothing expected", bif.result);
      end else begin
        sb_exp = exp_q.pop_front();
        if (bif.result !== sb_exp) begin
          n_fail++;
          $display("FAIL sb_result got=%h expected=%h", bif.result, sb_exp);
        end
      end
    end
  end

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int eff_n(input int v);
    if (v == 0) return 1;
    if (v > NBITS) return NBITS;
    return v;
  endfunction

  // Decision k is comp_out during comparison cycle k; the first decision ends highest.
  function automatic logic [NBITS-1:0] model_result(input int n, input logic [NBITS-1:0] dec);
    logic [NBITS-1:0] r;
    r = '0;
    for (int k = 0; k < eff_n(n); k++) r = {r[NBITS-2:0], dec[k]};
    return r;
  endfunction

  // Codes: 1 init, 2 samp, 3 comp, 4 logic, 5 done, 0 busy with nothing, 6 overlap, 7 busy low.
  function automatic int cur_code();
    int nh;
    nh = int'(bif.seq_init) + int'(bif.seq_samp) + int'(bif.seq_comp) + int'(bif.seq_logic);
    if (nh > 1) return 6;
    if (bif.busy !== 1'b1) return 7;
    if (bif.seq_init === 1'b1) return 1;
    if (bif.seq_samp === 1'b1) return 2;
    if (bif.seq_comp === 1'b1) return 3;
    if (bif.seq_logic === 1'b1) return 4;
    if (bif.done === 1'b1) return 5;
    return 0;
  endfunction

  // Index of the first trace entry that differs from the timing model, or -1 when it matches.
  function automatic int trace_mismatch(input int ti, input int ts, input int tc, input int tl, input int n);
    int e[$];
    int len;
    for (int i = 0; i < eff(ti); i++) e.push_back(1);
    for (int i = 0; i < eff(ts); i++) e.push_back(2);
    for (int j = 0; j < eff_n(n); j++) begin
      for (int i = 0; i < eff(tc); i++) e.push_back(3);
      for (int i = 0; i < eff(tl); i++) e.push_back(4);
    end
    e.push_back(5);
    len = (e.size() > trace.size()) ? e.size() : trace.size();
    for (int i = 0; i < len; i++) begin
      if (i >= e.size() || i >= trace.size()) return i;
      if (e[i] != trace[i]) return i;
    end
    return -1;
  endfunction

  // Starts one conversion, scrambles the inputs after acceptance, records the phase trace up to done.
  task automatic run_conv(input int ti, input int ts, input int tc, input int tl, input int n,
                          input logic [NBITS-1:0] dec, input bit poke_start, output bit timeout);
    int  k;
    bit  prev_comp;
    bit  fin;
    k = 0;
    prev_comp = 1'b0;
    fin = 1'b0;
    trace.delete();
    @(negedge clk);
    bif.t_init   = CNT_W'(ti);
    bif.t_samp   = CNT_W'(ts);
    bif.t_comp   = CNT_W'(tc);
    bif.t_logic  = CNT_W'(tl);
    bif.n_cycles = NC_W'(n);
    bif.comp_out = dec[0];
    bif.start    = 1'b1;
    exp_q.push_back(model_result(n, dec));
    @(negedge clk);
    bif.start    = 1'b0;
    bif.t_init   = CNT_W'($urandom);
    bif.t_samp   = CNT_W'($urandom);
    bif.t_comp   = CNT_W'($urandom);
    bif.t_logic  = CNT_W'($urandom);
    bif.n_cycles = NC_W'($urandom);
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      trace.push_back(cur_code());
      if (bif.seq_comp === 1'b1 && !prev_comp) begin
        if (k < NBITS) bif.comp_out = dec[k];
        k++;
      end
      prev_comp = (bif.seq_comp === 1'b1);
      if (bif.done === 1'b1) fin = 1'b1;
      bif.start = (poke_start && cyc == 3) ? 1'b1 : 1'b0;
      if (!fin) @(negedge clk);
    end
    bif.start = 1'b0;
    timeout = !fin;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({bif.seq_init, bif.seq_samp, bif.seq_comp, bif.seq_logic, bif.busy, bif.done} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b expected=000000",
               {bif.seq_init, bif.seq_samp, bif.seq_comp, bif.seq_logic, bif.busy, bif.done});
    end
    n_tests++;
    if (bif.result !== '0) begin
      n_fail++;
      $display("FAIL reset_result got=%h expected=0000", bif.result);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (bif.busy !== 1'b0 || cur_code() != 7) begin
      n_fail++;
      $display("FAIL reset_idle busy=%b expected 0 with no phase", bif.busy);
    end
  endtask

  task automatic test_timing();
    bit to;
    int mm;
    run_conv(2, 3, 1, 2, 4, 16'b1101, 1'b0, to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL timing_timeout no done within bound"); end
    n_tests++;
    if (trace.size() != 18) begin
      n_fail++;
      $display("FAIL timing_done_cycle done at cycle %0d expected 18", trace.size());
    end
    mm = trace_mismatch(2, 3, 1, 2, 4);
    n_tests++;
    if (mm != -1) begin
      n_fail++;
      $display("FAIL timing_trace first bad cycle %0d code=%0d", mm, (mm >= 0 && mm < trace.size()) ? trace[mm] : -1);
    end
    @(negedge clk);
    n_tests++;
    if (bif.done !== 1'b0 || bif.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timing_done_width done=%b busy=%b expected 0 0", bif.done, bif.busy);
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if (bif.result !== 16'h000B) begin
      n_fail++;
      $display("FAIL decisions_hold got=%h expected=000b", bif.result);
    end
  endtask

  task automatic test_boundaries();
    bit to;
    int mm;
    logic [NBITS-1:0] d;
    run_conv(0, 0, 0, 0, 0, '1, 1'b0, to);
    mm = trace_mismatch(1, 1, 1, 1, 1);
    n_tests++;
    if (to || mm != -1 || trace.size() != 5) begin
      n_fail++;
      $display("FAIL zero_params timeout=%0d bad_cycle=%0d len=%0d expected len 5", to, mm, trace.size());
    end
    d = NBITS'($urandom);
    run_conv(1, 1, 1, 2, 31, d, 1'b0, to);
    mm = trace_mismatch(1, 1, 1, 2, 16);
    n_tests++;
    if (to || mm != -1) begin
      n_fail++;
      $display("FAIL clamp_n31 timeout=%0d bad_cycle=%0d len=%0d expected len %0d", to, mm, trace.size(), 2 + 16 * 3 + 1);
    end
  endtask

  task automatic test_busy_start();
    bit to;
    int mm;
    bit stray;
    run_conv(1, 2, 2, 2, 3, NBITS'($urandom), 1'b1, to);
    mm = trace_mismatch(1, 2, 2, 2, 3);
    n_tests++;
    if (to || mm != -1) begin
      n_fail++;
      $display("FAIL busy_start_trace timeout=%0d bad_cycle=%0d", to, mm);
    end
    stray = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bif.busy !== 1'b0 || cur_code() != 7) stray = 1'b1;
    end
    n_tests++;
    if (stray) begin
      n_fail++;
      $display("FAIL busy_start_queued busy=%b expected 0 after done", bif.busy);
    end
  endtask

  task automatic test_random();
    bit to;
    int mm;
    int ti, ts, tc, tl, n;
    for (int it = 0; it < 4; it++) begin
      ti = $urandom_range(0, 4);
      ts = $urandom_range(0, 4);
      tc = $urandom_range(1, 3);
      tl = $urandom_range(2, 4);
      n  = (it == 0) ? 16 : $urandom_range(1, 16);
      run_conv(ti, ts, tc, tl, n, NBITS'($urandom), 1'b0, to);
      mm = trace_mismatch(ti, ts, tc, tl, n);
      n_tests++;
      if (to || mm != -1) begin
        n_fail++;
        $display("FAIL random_trace it=%0d t=%0d/%0d/%0d/%0d n=%0d timeout=%0d bad_cycle=%0d",
                 it, ti, ts, tc, tl, n, to, mm);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    bit stray;
    bit to;
    int mm;
    seen = 1'b0;
    @(negedge clk);
    bif.t_init = 8'd1; bif.t_samp = 8'd1; bif.t_comp = 8'd10; bif.t_logic = 8'd1;
    bif.n_cycles = NC_W'(2);
    bif.start = 1'b1;
    @(negedge clk);
    bif.start = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (bif.seq_comp === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    repeat (4) @(negedge clk);
    n_tests++;
    if (!seen || bif.seq_comp !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_setup seq_comp=%b expected 1 at compare cycle 5", bif.seq_comp);
    end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({bif.seq_init, bif.seq_samp, bif.seq_comp, bif.seq_logic, bif.busy} !== 5'b0 || bif.result !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_abort seq/busy=%b result=%h expected 00000 0000",
               {bif.seq_init, bif.seq_samp, bif.seq_comp, bif.seq_logic, bif.busy}, bif.result);
    end
    @(negedge clk);
    reset = 1'b0;
    stray = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bif.busy !== 1'b0 || cur_code() != 7) stray = 1'b1;
    end
    n_tests++;
    if (stray) begin
      n_fail++;
      $display("FAIL reset_mid_restart busy=%b expected idle without a fresh start", bif.busy);
    end
    run_conv(1, 1, 1, 2, 2, 16'b01, 1'b0, to);
    mm = trace_mismatch(1, 1, 1, 2, 2);
    n_tests++;
    if (to || mm != -1) begin
      n_fail++;
      $display("FAIL reset_mid_fresh timeout=%0d bad_cycle=%0d", to, mm);
    end
  endtask

`ifdef FRIDA_SEQ_AUTO_REPEAT_EN
  task automatic test_auto_repeat();
    int  dn;
    int  prev;
    int  c;
    bit  busy_drop;
    bit  gap;
    bit  drop_next;
    dn = 0; prev = 0; busy_drop = 1'b0; gap = 1'b0; drop_next = 1'b0;
    @(negedge clk);
    bif.t_init = 8'd1; bif.t_samp = 8'd1; bif.t_comp = 8'd1; bif.t_logic = 8'd2;
    bif.n_cycles = NC_W'(2);
    bif.comp_out = 1'b1;
    bif.auto_repeat = 1'b1;
    bif.start = 1'b1;
    repeat (3) exp_q.push_back(16'h0003);
    @(negedge clk);
    bif.start = 1'b0;
    for (int cyc = 0; cyc < 500 && dn < 3; cyc++) begin
      c = cur_code();
      if (c == 7) busy_drop = 1'b1;
      if (prev == 5 && c != 1) gap = 1'b1;
      if (drop_next) bif.auto_repeat = 1'b0;
      if (c == 5) begin
        dn++;
        if (dn == 2) drop_next = 1'b1;
      end
      prev = c;
      if (dn < 3) @(negedge clk);
    end
    n_tests++;
    if (dn != 3 || busy_drop || gap) begin
      n_fail++;
      $display("FAIL auto_repeat done_pulses=%0d expected 3 busy_drop=%0d gap=%0d", dn, busy_drop, gap);
    end
    @(negedge clk);
    n_tests++;
    if (bif.busy !== 1'b0 || cur_code() != 7) begin
      n_fail++;
      $display("FAIL auto_repeat_stop busy=%b expected 0 after final done", bif.busy);
    end
  endtask
`endif

  initial begin
    reset        = 1'b1;
    bif.start    = 1'b0;
    bif.t_init   = '0;
    bif.t_samp   = '0;
    bif.t_comp   = '0;
    bif.t_logic  = '0;
    bif.n_cycles = '0;
    bif.comp_out = 1'b0;
`ifdef FRIDA_SEQ_AUTO_REPEAT_EN
    bif.auto_repeat = 1'b0;
`endif
    test_reset();
    test_timing();
    test_boundaries();
    test_busy_start();
    test_random();
    test_reset_mid();
`ifdef FRIDA_SEQ_AUTO_REPEAT_EN
    test_auto_repeat();
`endif
    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover pending=%0d expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frida_seq_ctrl.md
Name: frida_seq_ctrl

Overview:
- Conversion sequencer that drives the four sequencing clocks (seq_init, seq_samp, seq_comp, seq_logic) into the FRIDA core.
- Captures the muxed comparator output (comp_out) returned by the core and assembles the per-conversion decision word.
- Sits directly upstream of the core, on the test/readout side: its seq_* outputs feed the core's LVDS RX pads, and it consumes the core's comp_out from the LVDS TX pad.

Parameters:
- NBITS, 16, maximum comparison cycles per conversion; width of result.
- CNT_W, 8, width of each phase-duration field and of the phase counter.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle conversion request.
- t_init  input  CNT_W  seq_init high time, in clk cycles.
- t_samp  input  CNT_W  seq_samp high time, in clk cycles.
- t_comp  input  CNT_W  seq_comp high time, in clk cycles.
- t_logic  input  CNT_W  seq_logic high time, in clk cycles.
- n_cycles  input  $clog2(NBITS)+1  comparison cycles per conversion.
- comp_out  input  1  comparator decision from the core; asynchronous to clk.
- seq_init  output  1  init phase clock to the core.
- seq_samp  output  1  sample phase clock to the core.
- seq_comp  output  1  compare phase clock to the core.
- seq_logic  output  1  update/logic phase clock to the core.
- busy  output  1  high from start acceptance until the done cycle, inclusive.
- done  output  1  one-cycle pulse when result is valid.
- result  output  NBITS  decision word of the last conversion.

Behaviour:
- Reset: all seq_* = 0, busy = 0, done = 0, result = 0, FSM = IDLE, synchroniser flops = 0. Reset asserted mid-conversion aborts immediately; all seq_* drop to 0 asynchronously.
- All seq_* outputs come directly from flops (glitch-free). At most one seq_* is high in any cycle.
- Parameter latching:
  - t_* and n_cycles are captured on the cycle start is accepted. Input changes during a conversion have no effect.
  - A duration of 0 is treated as 1.
  - n_cycles = 0 is treated as 1; n_cycles > NBITS is clamped to NBITS.
- start is accepted only in IDLE. start while busy is ignored; it is not queued.
- FSM states: IDLE, INIT, SAMP, COMP, LOGIC, DONE.
  - IDLE: on start, go to INIT on the next edge. result clears to 0 and busy rises on that edge.
  - INIT: seq_init = 1 for t_init cycles, then SAMP.
  - SAMP: seq_samp = 1 for t_samp cycles, then COMP.
  - COMP: seq_comp = 1 for t_comp cycles, then LOGIC.
  - LOGIC: seq_logic = 1 for t_logic cycles.
    - On the final LOGIC cycle, the synchronised comp_out is shifted into result: result <= {result[NBITS-2:0], comp_sync}.
    - Then go to COMP if fewer than n_cycles decisions have been taken, otherwise go to DONE.
  - DONE: one cycle with done = 1, busy = 1, all seq_* = 0. Then IDLE.
- comp_out passes through a 2-flop synchroniser. The sampled value is comp_out as it was 2 clk cycles before the final LOGIC cycle. Benches must hold comp_out stable for at least 3 cycles before the end of LOGIC.
- Bit order: the first decision ends in bit n_cycles-1 and the last decision in bit 0. Bits above n_cycles-1 read 0.
- Conversion length: t_init + t_samp + n_cycles*(t_comp + t_logic) cycles from the first INIT cycle to the last LOGIC cycle, followed by 1 DONE cycle. Values are after the 0-to-1 substitution.
- result holds its value from DONE until the next accepted start.

Optional Feature:
- Macro: FRIDA_SEQ_AUTO_REPEAT_EN.
- Defined:
  - Adds input port auto_repeat (1 bit).
  - If auto_repeat = 1 in the DONE cycle, the FSM goes directly to INIT. It reuses the latched timing, clears result, and keeps busy = 1. done still pulses for one cycle.
  - Deasserting auto_repeat lets the conversion in progress finish, then returns to IDLE.
- Undefined: the port is absent and DONE always returns to IDLE.

Test Plan:
- Reset mid-COMP, with t_comp = 10 and reset pulsed at cycle 5 → all seq_* and busy go to 0 immediately; result = 0; FSM restarts only on a fresh start.
- Timing, with t_init = 2, t_samp = 3, t_comp = 1, t_logic = 2, n_cycles = 4 → seq_init high 2 cycles, seq_samp high 3, then 4 × (seq_comp 1 + seq_logic 2); done at cycle 18 after the first INIT cycle; never two seq_* high together.
- Decisions, with n_cycles = 4 and comp_out driven 1, 0, 1, 1 per cycle (held ≥ 3 cycles before the end of LOGIC) → result = 16'h000B with done pulsed once.
- Boundaries: t_* = 0 behaves as 1; n_cycles = 0 gives 1 decision; n_cycles = 31 gives 16 decisions. start during busy is ignored. Changing t_comp mid-conversion has no effect on the running conversion.
- FRIDA_SEQ_AUTO_REPEAT_EN, with auto_repeat = 1 for 3 conversions then dropped → back-to-back conversions with INIT the cycle after DONE; 3 done pulses; busy never drops until the final IDLE.
